// File: rtl/cpu_pkg.sv
// Shared definitions for the 32-bit pipelined core: ALU opcodes and datapath defaults.
package cpu_pkg;

    localparam int CPU_WIDTH = 32;
    localparam int CPU_RAW   = 5;

    localparam logic [1:0] ALUC_ADD = 2'b00;
    localparam logic [1:0] ALUC_SUB = 2'b01;
    localparam logic [1:0] ALUC_AND = 2'b10;
    localparam logic [1:0] ALUC_OR  = 2'b11;

endpackage

// File: rtl/fwd_mux.sv
// Per-source operand forwarding: EX result beats MEM write-back beats register file.
module fwd_mux #(
    parameter int WIDTH = 32,
    parameter int RAW   = 5
) (
    input  logic [RAW-1:0]   i_src,
    input  logic             i_ex_en,
    input  logic [RAW-1:0]   i_ex_rd,
    input  logic [WIDTH-1:0] i_ex_data,
    input  logic             i_mem_wreg,
    input  logic [RAW-1:0]   i_mem_rd,
    input  logic [WIDTH-1:0] i_mem_data,
    input  logic [WIDTH-1:0] i_rf_data,
    output logic [WIDTH-1:0] o_data
);

    always_comb begin
        // NOTE: default first so every path assigns o_data and no latch is inferred.
        o_data = i_rf_data;
        if (i_src != '0) begin
            if (i_ex_en && i_ex_rd == i_src) begin
                o_data = i_ex_data;
            end else if (i_mem_wreg && i_mem_rd == i_src) begin
                o_data = i_mem_data;
            end
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM forwarding, load-use stall, flush and
// valid/ready handshake on both sides.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int WIDTH = CPU_WIDTH,
    parameter int RAW   = CPU_RAW
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [RAW-1:0]   Rs,
    input  logic [RAW-1:0]   Rt,
    input  logic             Use_rs,
    input  logic             Use_rt,
    input  logic [WIDTH-1:0] Qa,
    input  logic [WIDTH-1:0] Qb,
    input  logic [WIDTH-1:0] Imm,
    input  logic             Aluimm,
    input  logic [1:0]       Aluc_in,
    input  logic             Wreg_in,
    input  logic             M2reg_in,
    input  logic [RAW-1:0]   Rd_in,
    input  logic [WIDTH-1:0] Ex_R,
    input  logic             Mem_wreg,
    input  logic [RAW-1:0]   Mem_rd,
    input  logic [WIDTH-1:0] Mem_data,
    input  logic             Flush,
    input  logic             Out_ready,
    output logic             Valid,
    output logic [WIDTH-1:0] X,
    output logic [WIDTH-1:0] Y,
    output logic [1:0]       Aluc,
    output logic [WIDTH-1:0] Store_data,
    output logic             Wreg,
    output logic             M2reg,
    output logic [RAW-1:0]   Rd
);

    logic             r_valid;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_store;
    logic [1:0]       r_aluc;
    logic             r_wreg;
    logic             r_m2reg;
    logic [RAW-1:0]   r_rd;

    logic             w_advance;
    logic             w_hazard;
    logic             w_ex_fwd_en;
    logic [WIDTH-1:0] w_fwd_rs;
    logic [WIDTH-1:0] w_fwd_rt;

    assign w_advance = ~r_valid | Out_ready;
    assign w_hazard  = r_valid & r_m2reg & r_wreg & (r_rd != '0) &
                       ((Use_rs & (Rs == r_rd)) | (Use_rt & (Rt == r_rd)));
    assign In_ready  = w_advance & ~w_hazard;

    // A held load has no result yet, so it must never be an EX forwarding source.
    assign w_ex_fwd_en = r_valid & r_wreg & ~r_m2reg;

    fwd_mux #(.WIDTH(WIDTH), .RAW(RAW)) u_fwd_rs (
        .i_src      (Rs),
        .i_ex_en    (w_ex_fwd_en),
        .i_ex_rd    (r_rd),
        .i_ex_data  (Ex_R),
        .i_mem_wreg (Mem_wreg),
        .i_mem_rd   (Mem_rd),
        .i_mem_data (Mem_data),
        .i_rf_data  (Qa),
        .o_data     (w_fwd_rs)
    );

    fwd_mux #(.WIDTH(WIDTH), .RAW(RAW)) u_fwd_rt (
        .i_src      (Rt),
        .i_ex_en    (w_ex_fwd_en),
        .i_ex_rd    (r_rd),
        .i_ex_data  (Ex_R),
        .i_mem_wreg (Mem_wreg),
        .i_mem_rd   (Mem_rd),
        .i_mem_data (Mem_data),
        .i_rf_data  (Qb),
        .o_data     (w_fwd_rt)
    );

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_valid <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_store <= '0;
            r_aluc  <= '0;
            r_wreg  <= 1'b0;
            r_m2reg <= 1'b0;
            r_rd    <= '0;
        end else if (Flush) begin
            r_valid <= 1'b0;
        end else if (w_advance) begin
            if (w_hazard) begin
                r_valid <= 1'b0;
            end else begin
                r_valid <= In_valid;
                if (In_valid) begin
                    r_x     <= w_fwd_rs;
                    r_y     <= Aluimm ? Imm : w_fwd_rt;
                    r_store <= w_fwd_rt;
                    r_aluc  <= Aluc_in;
                    r_wreg  <= Wreg_in;
                    r_m2reg <= M2reg_in;
                    r_rd    <= Rd_in;
                end
            end
        end
    end

    assign Valid      = r_valid;
    assign X          = r_x;
    assign Y          = r_y;
    assign Aluc       = r_aluc;
    assign Store_data = r_store;
    assign Wreg       = r_valid & r_wreg;
    assign M2reg      = r_valid & r_m2reg;
    assign Rd         = r_rd;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage for the 32-bit pipelined core. It sits directly upstream of the combinational ALU and registers everything that stage needs: operand `X`, operand `Y`, opcode `Aluc`, and the write-back tags. It resolves RAW hazards in two ways: it forwards from the EX and MEM stages, and it inserts a one-bubble stall for a load-use hazard. It also honours a valid/ready handshake on both sides and a flush from branch resolution.

## Interface
Parameters:
- `WIDTH`, 32, datapath width
- `RAW`, 5, register-address width

Ports:
- `Clk`  in  1  clock, all state on rising edge
- `Rst`  in  1  synchronous, active-high reset
- `In_valid`  in  1  decode beat present
- `In_ready`  out  1  stage accepts decode beat this cycle
- `Rs`, `Rt`  in  RAW  source register numbers
- `Use_rs`, `Use_rt`  in  1  source actually read by instruction
- `Qa`, `Qb`  in  WIDTH  register-file read data for Rs/Rt
- `Imm`  in  WIDTH  sign/zero-extended immediate
- `Aluimm`  in  1  Y takes Imm instead of Rt value
- `Aluc_in`  in  2  ALU op: 00 add, 01 sub, 10 and, 11 or
- `Wreg_in`, `M2reg_in`  in  1  writes register / is a load
- `Rd_in`  in  RAW  destination register
- `Ex_R`  in  WIDTH  ALU result of the instruction currently held here
- `Mem_wreg`  in  1  MEM-stage instruction writes register
- `Mem_rd`  in  RAW  MEM-stage destination register
- `Mem_data`  in  WIDTH  MEM-stage write-back value
- `Flush`  in  1  squash held and incoming instruction
- `Out_ready`  in  1  EX/MEM register accepts this cycle
- `Valid`  out  1  held instruction valid
- `X`, `Y`  out  WIDTH  ALU operands
- `Aluc`  out  2  ALU op
- `Store_data`  out  WIDTH  forwarded Rt value
- `Wreg`, `M2reg`  out  1  write-back control, forced 0 when `Valid` = 0
- `Rd`  out  RAW  destination register

## Operation
- `advance` = ~`Valid` | `Out_ready`.
- Load-use `hazard` = `Valid` & `M2reg` & `Wreg` & (`Rd` ≠ 0) & ((`Use_rs` & `Rs` == `Rd`) | (`Use_rt` & `Rt` == `Rd`)).
- `In_ready` = `advance` & ~`hazard`. The signal is combinational and does not depend on `In_valid`.
- Forwarding, evaluated per source with priority EX > MEM > register file:
  - The EX source is taken when `Valid` & `Wreg` & ~`M2reg` & `Rd` ≠ 0 & `Rd` == src. Its value is `Ex_R`.
  - The MEM source is taken when `Mem_wreg` & `Mem_rd` ≠ 0 & `Mem_rd` == src. Its value is `Mem_data`.
  - Otherwise the register-file value `Qa`/`Qb` is used. A source of r0 always yields `Qa`/`Qb`.
- Captured operand values:
  - `X` ← forwarded Rs.
  - `Store_data` ← forwarded Rt.
  - `Y` ← `Aluimm` ? `Imm` : forwarded Rt.
- Next-state rules, in priority order:
  1. `Rst`: all outputs 0.
  2. `Flush`: `Valid` ← 0. A beat handshaken in the same cycle is accepted and discarded.
  3. `advance` & `hazard`: `Valid` ← 0 (bubble). Payload does not care.
  4. `advance`: `Valid` ← `In_valid`. When `In_valid` is set, capture the full payload.
  5. Otherwise hold everything.
- A bubble (`Valid` = 0) presents `Wreg` = `M2reg` = 0 so it can never write back.

## Timing
- Latency is 1 cycle from accepted beat to `X`/`Y`/`Aluc` valid.
- Throughput is 1 beat/cycle with no hazard.
- A load-use hazard costs exactly 1 bubble. On the next cycle the load sits in MEM and the value arrives through MEM forwarding.
- The `Out_ready` low path holds all outputs stable. `Ex_R` is allowed to depend combinationally on the held `X`/`Y`, and there is no loop because capture uses registered state only.
- Reset mid-stall drops the held instruction and deasserts `Valid` next cycle.
- When `Flush` and `hazard` occur together, flush wins and `In_ready` follows the hazard rule.

## Structure
- `cpu_pkg` holds the `ALUC_ADD`/`SUB`/`AND`/`OR` localparams and the `WIDTH`/`RAW` defaults.
- Sub-module `fwd_mux` takes src, the EX/MEM tags and data, and the regfile data, and returns the forwarded value. It is instantiated twice, for Rs and Rt.

## Test plan
- Reset then idle → all outputs 0. `In_ready` = 1.
- `add` Rs=1, Rt=2 with Qa=5, Qb=7, no forward → next cycle `X`=5, `Y`=7, `Aluc`=00, `Valid`=1.
- Back-to-back dependence:
  - Stimulus: held instruction writes r3 with `Ex_R`=0x10; next beat reads Rs=3 with Qa=0. The MEM stage also writes r3 with 0x20.
  - Required response: `X`=0x10 (EX priority).
- Load r4, then use r4:
  - The use beat sees `In_ready`=0 for 1 cycle, then a bubble with `Valid`=0, `Wreg`=0.
  - Next cycle `X` = `Mem_data`.
- r0 as source with EX `Rd`=0 and `Ex_R`=0xFF → `X` = `Qa` (0).
- `Out_ready`=0 for 3 cycles → outputs stable.
- `Flush` during the stall → `Valid`=0 next cycle and the concurrent beat is dropped.
